// File: rtl/apb3_cmd_master.sv
// apb3_cmd_master
//   Fabric-side APB3 initiator. Accepts single-beat read/write commands on a
//   valid/ready handshake, runs one APB3 SETUP/ACCESS transfer per command and
//   returns read data plus error/timeout status on a response handshake.
//   Only one transfer is outstanding at a time.
//
// Parameters
//   ADDR_W  : PADDR / cmd_addr width
//   DATA_W  : PWDATA / PRDATA / rsp_rdata width
//   TIMEOUT : ACCESS cycles with PREADY low before abort (0 = never abort)
//
// Ports
//   PCLK, PRESET               : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command handshake
//   rsp_valid/ready/rdata/err/timeout : response handshake
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : APB3 request outputs
//   PRDATA, PREADY, PSLVERR     : APB3 slave returns
module apb3_cmd_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               to_q, to_d;
  logic               psel_q, penable_q, rsp_valid_q, cmd_ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone is the handshake
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the timeout cycle wins
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          to_d    = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/APB strobes are decoded from the next state so they come
  // straight out of flops and line up with the state they describe.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      to_q        <= to_d;
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= (state_d == RESP);
      cmd_ready_q <= (state_d == IDLE);
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Scoreboard bench for apb3_cmd_master with TIMEOUT = 4.
//   driver  : issues commands, predicts accept cycles, pushes expectations
//   slave   : APB slave model following a per-transfer plan (wait count,
//             error, read data); drives PSLVERR high during wait cycles
//   monitor : pops expectations on rsp_valid, checks latency, payload,
//             response hold and backpressure behaviour
module tb_apb3_cmd_master;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb3_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          err;
    int          hold;
    int          idle;
  } cmd_t;

  typedef struct {
    cmd_t c;
    int   t_acc;
  } exp_t;

  cmd_t slv_q[$];
  exp_t exp_q[$];
  cmd_t plan_q[$];

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_busy = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(bit wr, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              int w, bit e, int h, int i);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.rdata = rd;
    c.waits = w; c.err = e; c.hold = h; c.idle = i;
    return c;
  endfunction

  // ---------------- APB slave model ----------------
  initial begin
    cmd_t cur;
    int   widx;
    bit   active;
    active = 0;
    widx = 0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) begin
        if (slv_q.size() == 0) begin
          chk("slave_plan_available", 0, 1);
          active = 0;
        end else begin
          cur = slv_q.pop_front();
          active = 1;
          widx = 0;
          chk("setup_paddr", PADDR, cur.addr);
          chk("setup_pwrite", PWRITE, cur.wr);
          if (cur.wr) chk("setup_pwdata", PWDATA, cur.wdata);
        end
      end
      if (PSEL && PENABLE && active) begin
        chk("access_paddr", PADDR, cur.addr);
        chk("access_pwrite", PWRITE, cur.wr);
        if (cur.wr) chk("access_pwdata", PWDATA, cur.wdata);
        if (widx == cur.waits) begin
          PREADY = 1'b1; PSLVERR = cur.err; PRDATA = cur.rdata;
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom;
        end
        widx++;
      end else begin
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t        e;
    bit          in_rsp, post, tmo;
    int          hold, n_acc;
    logic [31:0] cap_rdata;
    logic        cap_err, cap_to;
    in_rsp = 0; post = 0; hold = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      if (post) begin
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_cmd_ready", cmd_ready, 1);
        post = 0;
        rsp_ready = 1'b0;
      end
      if (!in_rsp && rsp_valid && !PRESET) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          tmo   = (e.c.waits >= TO);
          n_acc = tmo ? TO : e.c.waits + 1;
          chk("rsp_latency", cyc, e.t_acc + 2 + n_acc);
          chk("rsp_rdata", rsp_rdata, (tmo || e.c.wr) ? 32'h0 : e.c.rdata);
          chk("rsp_err", rsp_err, tmo ? 1'b1 : e.c.err);
          chk("rsp_timeout", rsp_timeout, tmo);
          chk("resp_psel", PSEL, 0);
          chk("resp_penable", PENABLE, 0);
          chk("resp_cmd_ready", cmd_ready, 0);
          cap_rdata = rsp_rdata; cap_err = rsp_err; cap_to = rsp_timeout;
          in_rsp = 1;
          hold = e.c.hold;
        end
      end else if (in_rsp) begin
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_rsp_rdata", rsp_rdata, cap_rdata);
        chk("hold_rsp_err", rsp_err, cap_err);
        chk("hold_rsp_timeout", rsp_timeout, cap_to);
        chk("hold_psel", PSEL, 0);
        chk("hold_cmd_ready", cmd_ready, 0);
      end
      if (in_rsp) begin
        if (hold == 0) begin
          rsp_ready = 1'b1;
          in_rsp = 0;
          post = 1;
        end else begin
          rsp_ready = 1'b0;
          hold--;
        end
      end
      mon_busy = in_rsp || post;
    end
  end

  // ---------------- driver ----------------
  // Issues one command; returns the accept cycle (-1 on a stuck handshake).
  task automatic issue(input cmd_t c, input bit expect_rsp, output int t_acc);
    int guard;
    repeat (c.idle) @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = c.wr; cmd_addr = c.addr; cmd_wdata = c.wdata;
    slv_q.push_back(c);
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_bound", 0, 1);
      t_acc = -1;
    end else begin
      t_acc = cyc;
      if (expect_rsp) begin
        exp_t e;
        e.c = c; e.t_acc = t_acc;
        exp_q.push_back(e);
      end
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || mon_busy) && guard < 500) begin
      @(negedge PCLK);
      guard++;
    end
    chk("drain_bound", (exp_q.size() == 0 && !mon_busy), 1);
  endtask

  initial begin
    int  t_acc, prev_t, r, n_prev;
    bit  have_prev;
    cmd_t c, p;
    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    PRESET = 1'b0;
    @(negedge PCLK);

    // directed
    plan_q.push_back(mk(1, 32'h4005_0000, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 0, 1));
    plan_q.push_back(mk(0, 32'h4005_0004, 32'h0, 32'h0000_1234, 2, 0, 0, 1));
    plan_q.push_back(mk(1, 32'h4005_0008, 32'hCAFE_F00D, 32'h0, 2, 1, 0, 1));
    plan_q.push_back(mk(0, 32'h4005_000C, 32'h0, 32'hAAAA_0001, 100, 0, 0, 1));
    plan_q.push_back(mk(0, 32'h4005_0010, 32'h0, 32'hBBBB_0002, 3, 0, 0, 1));
    plan_q.push_back(mk(0, 32'h4005_0014, 32'h0, 32'h1357_9BDF, 1, 0, 5, 1));
    for (int i = 0; i < 3; i++)
      plan_q.push_back(mk(i[0], 32'h4000_0100 + 32'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 0, 0, 0, 0));
    // random
    for (int i = 0; i < 60; i++)
      plan_q.push_back(mk(1'($urandom), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 6)), 1'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2))));

    have_prev = 0; prev_t = 0; n_prev = 0;
    while (plan_q.size() != 0) begin
      c = plan_q.pop_front();
      repeat (c.idle) @(negedge PCLK);
      c.idle = 0;
      r = cyc;
      issue(c, 1, t_acc);
      if (t_acc < 0) break;
      if (have_prev)
        chk("accept_cycle", t_acc, (r > prev_t + 3 + n_prev + p.hold) ? r : prev_t + 3 + n_prev + p.hold);
      else
        chk("accept_cycle", t_acc, r);
      have_prev = 1; prev_t = t_acc; p = c;
      n_prev = (c.waits >= TO) ? TO : c.waits + 1;
    end
    drain();

    // reset during an ACCESS wait state
    c = mk(0, 32'h4005_0020, 32'h0, 32'h7777_7777, 3, 0, 0, 0);
    issue(c, 0, t_acc);
    @(negedge PCLK);
    chk("pre_reset_in_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    c = mk(0, 32'h4005_0024, 32'h0, 32'h8888_0008, 1, 0, 1, 0);
    issue(c, 1, t_acc);
    drain();
    repeat (5) @(negedge PCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge PCLK);
    n_fail++;
    $display("FAIL watchdog: got cycle %0d expected completion before 20000", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb3_cmd_master.md
# apb3_cmd_master

Fabric-side APB3 initiator. It converts single-beat commands from fabric logic, using a valid/ready handshake, into compliant APB3 SETUP/ACCESS transfers, and returns read data and status on a response handshake. It drives the same APB3 slave bus that fabric peripherals such as `spi_pin` sit on. The MSS master port can then be replaced or supplemented by a fabric state machine, for example an autonomous touch-panel poller.

## Interface
- `ADDR_W`, default 32: PADDR / cmd_addr width.
- `DATA_W`, default 32: PWDATA / PRDATA width.
- `TIMEOUT`, default 255: maximum ACCESS wait cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- `PCLK` in 1: sole clock. All logic is on its rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data (ignored for reads).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out DATA_W: read data. 0 for writes and for timeouts.
- `rsp_err` out 1: PSLVERR seen, or timeout.
- `rsp_timeout` out 1: the transfer was aborted by timeout.
- `PSEL` out 1: APB select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB direction.
- `PADDR` out ADDR_W: APB address.
- `PWDATA` out DATA_W: APB write data.
- `PRDATA` in DATA_W: slave read data.
- `PREADY` in 1: slave ready.
- `PSLVERR` in 1: slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- **IDLE**
  - cmd_ready = 1.
  - When cmd_valid & cmd_ready: latch cmd_write, cmd_addr, cmd_wdata into PWRITE, PADDR, PWDATA, and go to SETUP.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Unconditionally go to ACCESS. Clear the wait counter.
- **ACCESS**
  - PSEL = 1, PENABLE = 1.
  - If PREADY = 1:
    - For reads, capture PRDATA into rsp_rdata. For writes, rsp_rdata = 0.
    - Set rsp_err = PSLVERR, rsp_timeout = 0.
    - Go to RESP.
  - Else if TIMEOUT != 0 and wait counter == TIMEOUT-1:
    - Abort: rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1.
    - Go to RESP.
  - Else increment the wait counter. The counter width is clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
- **RESP**
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_valid & rsp_ready. Then: rsp_valid = 0, go to IDLE.
- PADDR, PWDATA and PWRITE are stable from SETUP through the last ACCESS cycle. In IDLE and RESP they hold their last values.
- Only one transfer is outstanding. cmd_ready = 0 in SETUP, ACCESS and RESP.
- If PREADY = 1 in the same cycle that the timeout would fire, PREADY wins: normal completion.
- PSLVERR is sampled only in the ACCESS cycle where PREADY = 1.

## Timing
- **Reset values** (applied the cycle after PRESET is sampled high):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout = 0.
  - PADDR, PWDATA, rsp_rdata = 0.
  - cmd_ready = 1.
- **Reset mid-transfer:** PSEL and PENABLE drop the next cycle, any pending response is discarded, and no rsp_valid is produced.
- **Zero-wait transfer:**
  - Accept edge at cycle T.
  - SETUP is visible in T+1.
  - ACCESS in T+2, with PREADY high.
  - rsp_valid in T+3.
  - If rsp_ready = 1 in T+3, cmd_ready = 1 in T+4.
  - Minimum period is 4 cycles per transfer.
- **Wait states:** each cycle PREADY is low adds one ACCESS cycle and one cycle of latency.
- **Timeout:**
  - Exactly TIMEOUT ACCESS cycles are driven with PREADY low.
  - PSEL drops in the following cycle, which is also the first cycle with rsp_valid = 1.
- **Response hold:** rsp_valid stays high with constant data for any number of cycles while rsp_ready = 0. No new APB activity occurs during this time.

## Test plan
- **Zero-wait write.** Write addr 0x40050000, data 0xDEADBEEF, PREADY tied high → one SETUP cycle and one ACCESS cycle with PWRITE = 1 and the correct PADDR/PWDATA; rsp_valid at T+3 with rsp_err = 0 and rsp_rdata = 0.
- **Read with wait states.** Read addr 0x40050004; slave holds PREADY low for 2 cycles, then returns PRDATA = 0x00001234 → 3 ACCESS cycles; rsp_rdata = 0x1234, rsp_err = 0, rsp_valid at T+5.
- **Slave error.** Write with PSLVERR = 1 on the completing cycle → rsp_err = 1, rsp_timeout = 0. Also check that PSLVERR asserted during earlier wait cycles is ignored.
- **Timeout.** Set TIMEOUT = 4; PREADY is never asserted → exactly 4 ACCESS cycles, PSEL = 0 in the next cycle; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. Repeat with PREADY rising on the 4th wait cycle → normal completion.
- **Response backpressure.** Hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_valid and data remain stable, cmd_ready = 0, no PSEL. Issue back-to-back commands with rsp_ready = 1 → a 4-cycle period.
- **Reset mid-ACCESS.** Assert PRESET for 1 cycle during a wait state → the next cycle has PSEL = 0, PENABLE = 0, rsp_valid = 0, cmd_ready = 1. The next command completes normally.
